// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared constants and helpers for the Simon game core
package simon_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADD      = 3'd1;
    localparam logic [2:0] ST_SHOW_ON  = 3'd2;
    localparam logic [2:0] ST_SHOW_OFF = 3'd3;
    localparam logic [2:0] ST_INPUT    = 3'd4;
    localparam logic [2:0] ST_WIN      = 3'd5;
    localparam logic [2:0] ST_LOSE     = 3'd6;

    localparam int              LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Up to 8 buttons, so a fixed 8-bit result; callers keep the low NUM_BTN bits.
    function automatic logic [7:0] onehot(input logic [2:0] idx);
        return 8'b1 << idx;
    endfunction

endpackage

// File: rtl/simon_lfsr16.sv
// rtl/simon_lfsr16.sv - free-running 16-bit Galois LFSR with non-zero seed guard
module simon_lfsr16
    import simon_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

    always_ff @(posedge clk) begin
        if (reset)
            q <= SEED_NZ;
        else if (q[0])
            q <= (q >> 1) ^ LFSR_TAPS;
        else
            q <= q >> 1;
    end

endmodule

// File: rtl/simon_engine.sv
// rtl/simon_engine.sv - Simon game core: grows a random sequence, plays it back, checks the echo
module simon_engine
    import simon_pkg::*;
#(
    parameter int          NUM_BTN       = 4,
    parameter int          MAX_LEN       = 16,
    parameter int          SHOW_TICKS    = 50,
    parameter int          GAP_TICKS     = 25,
    parameter int          TIMEOUT_TICKS = 300,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    localparam int         IDX_W         = clog2(NUM_BTN),
    localparam int         LEN_W         = clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               start,
    input  logic [NUM_BTN-1:0] btn_rise,
    output logic [NUM_BTN-1:0] led,
    output logic               error_led,
    output logic               win,
    output logic               busy,
    output logic [LEN_W-1:0]   round,
    output logic [2:0]         state
);

    localparam int ADR_W     = clog2(MAX_LEN);
    localparam int MAX_TICKS = (SHOW_TICKS > GAP_TICKS)
                             ? ((SHOW_TICKS > TIMEOUT_TICKS) ? SHOW_TICKS : TIMEOUT_TICKS)
                             : ((GAP_TICKS > TIMEOUT_TICKS) ? GAP_TICKS : TIMEOUT_TICKS);
    localparam int TMR_W     = clog2(MAX_TICKS) + 1;

    localparam logic [TMR_W-1:0] SHOW_LAST    = TMR_W'(SHOW_TICKS - 1);
    localparam logic [TMR_W-1:0] GAP_LAST     = TMR_W'(GAP_TICKS - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_TICKS - 1);
    localparam logic [LEN_W-1:0] LEN_MAX      = LEN_W'(MAX_LEN);
    localparam logic [IDX_W+3:0] NB           = NUM_BTN[IDX_W+3:0];

    logic [15:0]        lfsr_q;
    logic               unused_lfsr;
    logic [IDX_W+3:0]   rnd;
    logic [IDX_W-1:0]   new_val;
    logic [IDX_W-1:0]   cur_val;
    logic [IDX_W-1:0]   press_idx;
    logic               press;
    logic               last_step;
    logic [7:0]         oh_cur;
    logic [7:0]         oh_press;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   ptr;
    logic [TMR_W-1:0]   timer;
    logic [NUM_BTN-1:0] press_led;
    logic [IDX_W-1:0]   mem [MAX_LEN];

    simon_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    assign unused_lfsr = ^lfsr_q[15:IDX_W+4];
    assign rnd         = lfsr_q[IDX_W+3:0];
    assign new_val     = IDX_W'(rnd % NB);
    assign cur_val     = mem[ptr[ADR_W-1:0]];
    assign last_step   = (ptr == len - 1'b1);
    assign press       = |btn_rise;
    assign oh_cur      = onehot(3'(cur_val));
    assign oh_press    = onehot(3'(press_idx));

    // Scan downwards so the lowest set bit wins when several buttons pulse together.
    always_comb begin
        press_idx = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--)
            if (btn_rise[i]) press_idx = IDX_W'(i);
    end

    always_comb begin
        led = '0;
        case (state)
            ST_SHOW_ON, ST_LOSE: led = oh_cur[NUM_BTN-1:0];
            ST_INPUT:            led = press_led;
            ST_WIN:              led = '1;
            default:             led = '0;
        endcase
    end

    assign error_led = (state == ST_LOSE);
    assign win       = (state == ST_WIN);
    assign busy      = (state == ST_ADD) || (state == ST_SHOW_ON) || (state == ST_SHOW_OFF);
    assign round     = len;

    always_ff @(posedge clk) begin
        if (!reset && state == ST_ADD)
            mem[len[ADR_W-1:0]] <= new_val;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            len       <= '0;
            ptr       <= '0;
            timer     <= '0;
            press_led <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_WIN, ST_LOSE: begin
                    if (start) begin
                        len   <= '0;
                        ptr   <= '0;
                        state <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    len   <= len + 1'b1;
                    ptr   <= '0;
                    timer <= '0;
                    state <= ST_SHOW_ON;
                end
                ST_SHOW_ON: begin
                    if (tick) begin
                        if (timer == SHOW_LAST) begin
                            timer <= '0;
                            state <= ST_SHOW_OFF;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                end
                ST_SHOW_OFF: begin
                    if (tick) begin
                        if (timer == GAP_LAST) begin
                            timer <= '0;
                            if (last_step) begin
                                ptr       <= '0;
                                press_led <= '0;
                                state     <= ST_INPUT;
                            end else begin
                                ptr   <= ptr + 1'b1;
                                state <= ST_SHOW_ON;
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                end
                ST_INPUT: begin
                    // A press outranks a tick in the same clk, including the expiring one.
                    if (press) begin
                        timer <= '0;
                        if (press_idx == cur_val) begin
                            press_led <= oh_press[NUM_BTN-1:0];
                            if (last_step)
                                state <= (len == LEN_MAX) ? ST_WIN : ST_ADD;
                            else
                                ptr <= ptr + 1'b1;
                        end else begin
                            state <= ST_LOSE;
                        end
                    end else if (tick) begin
                        if (timer == TIMEOUT_LAST)
                            state <= ST_LOSE;
                        else
                            timer <= timer + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_engine.sv
// tb/tb_simon_engine.sv - randomized self-checking bench for simon_engine
module tb_simon_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset   = 1'b1;
    logic       tick    = 1'b1;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic [3:0] btn_a   = '0;
    logic [2:0] btn_b   = '0;
    logic [3:0] led_a;
    logic [2:0] led_b;
    logic       err_a, win_a, busy_a;
    logic       err_b, win_b, busy_b;
    logic [1:0] round_a, round_b;
    logic [2:0] state_a, state_b;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] ref_lfsr = 16'hACE1;
    int seq_a[$];
    int seq_b[$];

    simon_engine #(.NUM_BTN(4), .MAX_LEN(3), .SHOW_TICKS(2), .GAP_TICKS(1),
                   .TIMEOUT_TICKS(5), .LFSR_SEED(16'hACE1)) dut_a (
        .clk(clk), .reset(reset), .tick(tick), .start(start_a), .btn_rise(btn_a),
        .led(led_a), .error_led(err_a), .win(win_a), .busy(busy_a),
        .round(round_a), .state(state_a));

    simon_engine #(.NUM_BTN(3), .MAX_LEN(3), .SHOW_TICKS(2), .GAP_TICKS(1),
                   .TIMEOUT_TICKS(5), .LFSR_SEED(16'hACE1)) dut_b (
        .clk(clk), .reset(reset), .tick(tick), .start(start_b), .btn_rise(btn_b),
        .led(led_b), .error_led(err_b), .win(win_b), .busy(busy_b),
        .round(round_b), .state(state_b));

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic logic [3:0] oh4(input int v);
        return 4'(1 << v);
    endfunction

    // Reference: the random value drawn in ADD is the current LFSR value mod NUM_BTN.
    always @(posedge clk) begin
        if (reset) begin
            ref_lfsr <= 16'hACE1;
        end else begin
            ref_lfsr <= lfsr_next(ref_lfsr);
            if (state_a == 3'd1) begin
                if (round_a == 2'd0) seq_a.delete();
                seq_a.push_back(int'(ref_lfsr[5:0]) % 4);
            end
            if (state_b == 3'd1) begin
                if (round_b == 2'd0) seq_b.delete();
                seq_b.push_back(int'(ref_lfsr[5:0]) % 3);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic do_reset();
        reset = 1'b1; tick = 1'b1; start_a = 1'b0; start_b = 1'b0; btn_a = '0; btn_b = '0;
        cyc(); cyc();
        reset = 1'b0;
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1; cyc(); start_a = 1'b0;
    endtask

    task automatic wait_state_a(input logic [2:0] s, input int budget, output bit ok);
        for (int i = 0; i < budget; i++) begin
            if (state_a == s) break;
            cyc();
        end
        ok = (state_a == s);
    endtask

    task automatic test_reset();
        reset = 1'b1; cyc(); cyc();
        compared++;
        if (state_a !== 3'd0) begin mismatched++; $display("FAIL reset_state: got %0d expected 0", state_a); end
        compared++;
        if (led_a !== 4'b0) begin mismatched++; $display("FAIL reset_led: got %b expected 0000", led_a); end
        compared++;
        if ({err_a, win_a, busy_a} !== 3'b000) begin mismatched++; $display("FAIL reset_flags: got %b expected 000", {err_a, win_a, busy_a}); end
        compared++;
        if (round_a !== 2'd0) begin mismatched++; $display("FAIL reset_round: got %0d expected 0", round_a); end
        reset = 1'b0;
        compared++;
        if (dut_a.u_lfsr.q !== 16'hACE1) begin mismatched++; $display("FAIL reset_lfsr_seed: got %h expected ace1", dut_a.u_lfsr.q); end
        cyc();
        compared++;
        if (dut_a.u_lfsr.q !== ref_lfsr) begin mismatched++; $display("FAIL lfsr_step: got %h expected %h", dut_a.u_lfsr.q, ref_lfsr); end
    endtask

    task automatic test_playback();
        do_reset();
        idle($urandom_range(0, 15));
        start_a = 1'b1; cyc(); start_a = 1'b0;
        compared++;
        if (state_a !== 3'd1 || busy_a !== 1'b1) begin mismatched++; $display("FAIL playback_add: state=%0d busy=%b expected 1/1", state_a, busy_a); end
        cyc();
        compared++;
        if (state_a !== 3'd2 || round_a !== 2'd1 || busy_a !== 1'b1 || led_a !== oh4(seq_a[0])) begin
            mismatched++; $display("FAIL playback_on1: state=%0d round=%0d busy=%b led=%b expected 2/1/1/%b", state_a, round_a, busy_a, led_a, oh4(seq_a[0]));
        end
        cyc();
        compared++;
        if (state_a !== 3'd2 || led_a !== oh4(seq_a[0])) begin mismatched++; $display("FAIL playback_on2: state=%0d led=%b expected 2/%b", state_a, led_a, oh4(seq_a[0])); end
        cyc();
        compared++;
        if (state_a !== 3'd3 || led_a !== 4'b0 || busy_a !== 1'b1) begin mismatched++; $display("FAIL playback_gap: state=%0d led=%b busy=%b expected 3/0000/1", state_a, led_a, busy_a); end
        cyc();
        compared++;
        if (state_a !== 3'd4 || busy_a !== 1'b0 || led_a !== 4'b0) begin mismatched++; $display("FAIL playback_input: state=%0d busy=%b led=%b expected 4/0/0000", state_a, busy_a, led_a); end
    endtask

    task automatic test_full_game();
        int k;
        int b;
        logic [2:0] prev;
        logic [3:0] exp_led;
        do_reset();
        idle($urandom_range(0, 15));
        pulse_start_a();
        for (int r = 1; r <= 3; r++) begin
            k = 0;
            prev = 3'd0;
            for (int n = 0; n < 60 && state_a != 3'd4; n++) begin
                if (state_a == 3'd2 && prev != 3'd2) begin
                    exp_led = (k < seq_a.size()) ? oh4(seq_a[k]) : 4'b0000;
                    compared++;
                    if (led_a !== exp_led) begin mismatched++; $display("FAIL game_playback r%0d step%0d: led=%b expected %b", r, k, led_a, exp_led); end
                    k++;
                end
                prev = state_a;
                cyc();
            end
            compared++;
            if (state_a !== 3'd4 || k != r) begin mismatched++; $display("FAIL game_reach_input r%0d: state=%0d steps=%0d expected 4/%0d", r, state_a, k, r); end
            for (int i = 0; i < r; i++) begin
                b = (1 << seq_a[i]) | (int'($urandom) & (15 << (seq_a[i] + 1)) & 15);
                btn_a = 4'(b); cyc(); btn_a = '0;
                if (i < r - 1) begin
                    compared++;
                    if (state_a !== 3'd4 || led_a !== oh4(seq_a[i])) begin mismatched++; $display("FAIL game_echo r%0d i%0d: state=%0d led=%b expected 4/%b", r, i, state_a, led_a, oh4(seq_a[i])); end
                end
            end
            if (r < 3) begin
                compared++;
                if (state_a !== 3'd1) begin mismatched++; $display("FAIL game_next_round r%0d: state=%0d expected 1", r, state_a); end
            end
        end
        compared++;
        if (state_a !== 3'd5 || win_a !== 1'b1 || led_a !== 4'b1111 || round_a !== 2'd3) begin
            mismatched++; $display("FAIL game_win: state=%0d win=%b led=%b round=%0d expected 5/1/1111/3", state_a, win_a, led_a, round_a);
        end
        for (int i = 0; i < 4; i++) begin
            btn_a = 4'($urandom_range(1, 15)); cyc();
        end
        btn_a = '0;
        compared++;
        if (state_a !== 3'd5 || led_a !== 4'b1111) begin mismatched++; $display("FAIL win_ignores_buttons: state=%0d led=%b expected 5/1111", state_a, led_a); end
    endtask

    task automatic test_wrong_button();
        bit ok;
        int wrong;
        do_reset();
        idle($urandom_range(0, 15));
        pulse_start_a();
        wait_state_a(3'd4, 40, ok);
        btn_a = oh4(seq_a[0]); cyc(); btn_a = '0;
        cyc();
        start_a = 1'b1; cyc(); start_a = 1'b0;
        compared++;
        if (state_a !== 3'd2 || round_a !== 2'd2) begin mismatched++; $display("FAIL start_ignored_in_show: state=%0d round=%0d expected 2/2", state_a, round_a); end
        wait_state_a(3'd4, 40, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL wrong_reach_input: state=%0d expected 4", state_a); end
        btn_a = oh4(seq_a[0]); cyc(); btn_a = '0;
        wrong = (seq_a[1] + 1 + int'($urandom_range(0, 2))) % 4;
        btn_a = oh4(wrong); cyc(); btn_a = '0;
        compared++;
        if (state_a !== 3'd6 || err_a !== 1'b1 || led_a !== oh4(seq_a[1])) begin
            mismatched++; $display("FAIL wrong_lose: state=%0d err=%b led=%b expected 6/1/%b", state_a, err_a, led_a, oh4(seq_a[1]));
        end
        pulse_start_a();
        compared++;
        if (state_a !== 3'd1 || err_a !== 1'b0) begin mismatched++; $display("FAIL lose_restart: state=%0d err=%b expected 1/0", state_a, err_a); end
        cyc();
        compared++;
        if (round_a !== 2'd1) begin mismatched++; $display("FAIL lose_restart_round: got %0d expected 1", round_a); end
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        for (int p = 0; p < 2; p++) begin
            do_reset();
            idle($urandom_range(0, 15));
            pulse_start_a();
            wait_state_a(3'd4, 40, ok);
            compared++;
            if (!ok) begin mismatched++; $display("FAIL timeout_reach_input p%0d: state=%0d expected 4", p, state_a); end
            n = 0;
            for (int c = 0; c < 200 && n < 5; c++) begin
                tick = 1'($urandom_range(0, 1));
                if (p == 1 && tick && n == 4) btn_a = oh4(seq_a[0]);
                cyc();
                btn_a = '0;
                if (tick) n++;
                compared++;
                if (n < 5) begin
                    if (state_a !== 3'd4) begin mismatched++; $display("FAIL timeout_early p%0d tick%0d: state=%0d expected 4", p, n, state_a); end
                end else if (p == 0) begin
                    if (state_a !== 3'd6 || err_a !== 1'b1 || led_a !== oh4(seq_a[0])) begin
                        mismatched++; $display("FAIL timeout_lose: state=%0d err=%b led=%b expected 6/1/%b", state_a, err_a, led_a, oh4(seq_a[0]));
                    end
                end else begin
                    if (state_a !== 3'd1 || err_a !== 1'b0) begin mismatched++; $display("FAIL timeout_press_priority: state=%0d err=%b expected 1/0", state_a, err_a); end
                end
            end
            tick = 1'b1;
            compared++;
            if (n < 5) begin mismatched++; $display("FAIL timeout_tick_budget p%0d: ticks=%0d expected 5", p, n); end
        end
    endtask

    task automatic test_multi_bit();
        bit ok;
        bit seen_one;
        int s;
        seen_one = 1'b0;
        for (int t = 0; t < 60 && !(seen_one && t >= 6); t++) begin
            do_reset();
            idle($urandom_range(0, 31));
            pulse_start_a();
            wait_state_a(3'd4, 40, ok);
            s = seq_a[0];
            btn_a = 4'b0110; cyc(); btn_a = '0;
            compared++;
            if (s == 1) begin
                seen_one = 1'b1;
                if (state_a !== 3'd1) begin mismatched++; $display("FAIL multi_bit_accept: state=%0d expected 1", state_a); end
            end else if (state_a !== 3'd6 || led_a !== oh4(s)) begin
                mismatched++; $display("FAIL multi_bit_reject: state=%0d led=%b expected 6/%b", state_a, led_a, oh4(s));
            end
        end
        compared++;
        if (!seen_one) begin mismatched++; $display("FAIL multi_bit_coverage: accepted=%0d expected 1", seen_one); end
    endtask

    task automatic test_num_btn3();
        bit seen;
        do_reset();
        for (int g = 0; g < 200; g++) begin
            idle($urandom_range(0, 7));
            start_b = 1'b1; cyc(); start_b = 1'b0;
            seen = 1'b0;
            for (int n = 0; n < 40 && state_b != 3'd4; n++) begin
                if (state_b == 3'd2 && !seen) begin
                    seen = 1'b1;
                    compared++;
                    if (seq_b.size() != 1 || seq_b[0] > 2 || led_b !== 3'(1 << seq_b[0])) begin
                        mismatched++; $display("FAIL btn3_value g%0d: led=%b expected %b", g, led_b, 3'(1 << seq_b[0]));
                    end
                end
                cyc();
            end
            for (int n = 0; n < 20 && state_b != 3'd6; n++) cyc();
            compared++;
            if (state_b !== 3'd6 || !seen) begin mismatched++; $display("FAIL btn3_game g%0d: state=%0d shown=%0d expected 6/1", g, state_b, seen); end
        end
    endtask

    task automatic test_reset_mid_show();
        do_reset();
        idle($urandom_range(0, 15));
        pulse_start_a();
        cyc();
        compared++;
        if (state_a !== 3'd2) begin mismatched++; $display("FAIL mid_show_setup: state=%0d expected 2", state_a); end
        reset = 1'b1; cyc(); reset = 1'b0;
        compared++;
        if (state_a !== 3'd0 || led_a !== 4'b0 || round_a !== 2'd0 || busy_a !== 1'b0) begin
            mismatched++; $display("FAIL mid_show_reset: state=%0d led=%b round=%0d busy=%b expected 0/0000/0/0", state_a, led_a, round_a, busy_a);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_playback();
        test_full_game();
        test_wrong_button();
        test_timeout();
        test_multi_bit();
        test_num_btn3();
        test_reset_mid_show();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
